color_cmd_ctrl: RTL
===================

COLOR_CMD_CTRL -- requirements
Module: color_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL set the max cycles allowed between header byte and data byte.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data/rx_perr valid.
REQ-006 rx_perr  input  1  parity error on current byte, qualified by rx_valid.
REQ-007 btn_req  input  1  button editor write request, held high until btn_ack.
REQ-008 btn_ch  input  2  button request channel.
REQ-009 btn_reg  input  4  button request register index.
REQ-010 btn_data  input  8  button request write data.
REQ-011 wr_en  output  1  one-cycle write strobe to color register file.
REQ-012 wr_ch  output  2  write channel.
REQ-013 wr_reg  output  4  write register index.
REQ-014 wr_data  output  8  write data.
REQ-015 btn_ack  output  1  one-cycle pulse, button request serviced.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err_cnt  output  8  saturating count of protocol errors.
REQ-018 frame_cnt  output  8  wrapping count of completed UART writes.

Function
REQ-019 States SHALL be IDLE, WAIT_DATA, UART_WR, BTN_WR; each write state SHALL last exactly one cycle.
REQ-020 UART frame: header byte (bit7=1, bit6=0, [5:4]=channel, [3:0]=register), then data byte (any value).
REQ-021 IDLE rules, rx_valid=1: valid header, no perr -> latch ch/reg, go WAIT_DATA, clear timeout counter; otherwise (bit7=0, bit6=1, or perr) -> discard, err_cnt+1, stay IDLE.
REQ-022 WAIT_DATA, rx_valid=1, rx_perr=0: latch data, go UART_WR.
REQ-023 WAIT_DATA, rx_valid=1, rx_perr=1: abort frame, err_cnt+1, go IDLE.
REQ-024 WAIT_DATA timeout counter SHALL increment each cycle without rx_valid; on reaching TIMEOUT-1 -> abort, err_cnt+1, go IDLE.
REQ-025 UART_WR: wr_en=1 with latched ch/reg/data; frame_cnt+1 (255 wraps to 0); latency = 1 cycle from data-byte rx_valid to wr_en.
REQ-026 Button service: in IDLE with btn_req=1 and rx_valid=0 -> latch btn_ch/reg/data, go BTN_WR.
REQ-027 BTN_WR: wr_en=1 with latched button fields and btn_ack=1 in the same cycle.
REQ-028 Arbitration: UART wins; IDLE with rx_valid=1 and btn_req=1 -> byte handled per REQ-021, button waits; button never serviced during WAIT_DATA.
REQ-029 rx_valid during UART_WR/BTN_WR SHALL be evaluated with IDLE rules (REQ-021), next state chosen accordingly; no byte dropped.
REQ-030 From UART_WR/BTN_WR with no rx_valid -> IDLE; pending btn_req then serviced on the following cycle.
REQ-031 err_cnt SHALL saturate at 255; at most one error counted per cycle.
REQ-032 wr_ch/wr_reg/wr_data SHALL hold last written values when wr_en=0.
REQ-033 At most one wr_en per cycle; wr_en and btn_ack never asserted outside write states.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, wr_en=0, btn_ack=0, busy=0, wr_ch=0, wr_reg=0, wr_data=0, err_cnt=0, frame_cnt=0, timeout counter=0, from any state including mid-frame.
REQ-035 A partial frame interrupted by reset SHALL produce no write; next byte after reset is treated as a header candidate.

Verification
REQ-036 Header 0x95 then data 0x21, no perr -> one wr_en cycle after data strobe, wr_ch=1, wr_reg=5, wr_data=0x21, frame_cnt=1.
REQ-037 Header 0x83 then data with rx_perr=1 -> no wr_en, err_cnt=1, state IDLE; then 0x83,0x7F -> write ch0 reg3 data 0x7F.
REQ-038 TIMEOUT=16, header 0xA2, no further bytes -> return to IDLE after 16 cycles, err_cnt=1; late data byte 0x10 -> discarded, err_cnt=2.
REQ-039 btn_req (ch2, reg4, 0x55) raised same cycle as header 0x81 -> UART frame (data 0x0A) written first, btn write ch2 reg4 0x55 follows with btn_ack, exactly one ack.
REQ-040 rst asserted in WAIT_DATA after header 0x90 -> all outputs zero next cycle; subsequent data byte 0x33 alone -> no write, err_cnt=1.
REQ-041 300 invalid bytes (bit7=0) -> err_cnt saturates at 255, no wr_en.

Source files
------------

// File: rtl/color_cmd_ctrl.sv
// Color register write controller: decodes two-byte UART frames (header + data)
// and arbitrates them against button-editor write requests, UART first.
module color_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_perr,
  input  logic       btn_req,
  input  logic [1:0] btn_ch,
  input  logic [3:0] btn_reg,
  input  logic [7:0] btn_data,
  output logic       wr_en,
  output logic [1:0] wr_ch,
  output logic [3:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       btn_ack,
  output logic       busy,
  output logic [7:0] err_cnt,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    UART_WR,
    BTN_WR
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    hdr_ch;
  logic [3:0]    hdr_reg;

  logic hdr_ok;
  logic take_hdr, take_data, take_btn, tmo_inc, err_inc;

  assign hdr_ok = (rx_data[7:6] == 2'b10) && !rx_perr;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n   = state;
    take_hdr  = 1'b0;
    take_data = 1'b0;
    take_btn  = 1'b0;
    tmo_inc   = 1'b0;
    err_inc   = 1'b0;
    case (state)
      WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_perr) begin
            err_inc = 1'b1;
            state_n = IDLE;
          end else begin
            take_data = 1'b1;
            state_n   = UART_WR;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_inc = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: begin
        // Write states evaluate incoming bytes exactly like IDLE so none are lost.
        if (rx_valid) begin
          if (hdr_ok) begin
            take_hdr = 1'b1;
            state_n  = WAIT_DATA;
          end else begin
            err_inc = 1'b1;
            state_n = IDLE;
          end
        end else if (state == IDLE && btn_req) begin
          take_btn = 1'b1;
          state_n  = BTN_WR;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  assign wr_en   = (state == UART_WR) || (state == BTN_WR);
  assign btn_ack = (state == BTN_WR);
  assign busy    = (state != IDLE);

  // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      hdr_ch    <= '0;
      hdr_reg   <= '0;
      wr_ch     <= '0;
      wr_reg    <= '0;
      wr_data   <= '0;
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      if (take_hdr) begin
        hdr_ch  <= rx_data[5:4];
        hdr_reg <= rx_data[3:0];
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      // Write fields only change when a write is launched, so they hold between strobes.
      if (take_data) begin
        wr_ch   <= hdr_ch;
        wr_reg  <= hdr_reg;
        wr_data <= rx_data;
      end else if (take_btn) begin
        wr_ch   <= btn_ch;
        wr_reg  <= btn_reg;
        wr_data <= btn_data;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (state == UART_WR) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
